// File: rtl/receptor_medida_serial_pkg.sv
// Purpose: shared types and constants for the receptor_medida_serial slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: receiver FSM state encoding, ASCII constants for the "XYZ#"
// frame format and a digit classifier used by the frame parser.
package receptor_medida_serial_pkg;

    // Receiver FSM states; the encoding is exported on db_estado.
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_PARITY    = 3'd3,
        ST_STOP      = 3'd4,
        ST_ENTREGA   = 3'd5,
        ST_WAIT_IDLE = 3'd6
    } estado_t;

    localparam logic [6:0] ASCII_HASH = 7'h23;
    localparam logic [6:0] ASCII_ZERO = 7'h30;
    localparam logic [6:0] ASCII_NINE = 7'h39;

    // True for '0'..'9'.
    function automatic logic eh_digito(input logic [6:0] c);
        return (c >= ASCII_ZERO) && (c <= ASCII_NINE);
    endfunction

endpackage

// File: rtl/receptor_medida_serial_rx_7E1.sv
// Purpose: 7E1 UART character receiver (mirror of tx_serial_7E1).
// Latency: o_pronto rises 1 cycle after the stop-bit sample cycle.
// Backpressure: none; every accepted character is presented for one cycle only.
//
// Ports:
//   i_clock, i_reset     system clock, synchronous active-high reset
//   i_rx                 raw RX line (asynchronous, idles high)
//   o_dados              last accepted character (stable while o_pronto)
//   o_pronto             1-cycle pulse per accepted character
//   o_erro_paridade      1-cycle pulse on even-parity mismatch
//   o_erro_frame         1-cycle pulse when the stop bit samples 0
//   o_estado             current FSM state
// Optional: RX_PARITY_CHECK_EN enables the parity check; when undefined the
// parity bit is simply skipped and o_erro_paridade stays 0.
module receptor_medida_serial_rx_7E1
    import receptor_medida_serial_pkg::*;
#(
    parameter int BAUD_DIV = 434,
    parameter int HALF_DIV = BAUD_DIV / 2
) (
    input  logic       i_clock,
    input  logic       i_reset,
    input  logic       i_rx,
    output logic [6:0] o_dados,
    output logic       o_pronto,
    output logic       o_erro_paridade,
    output logic       o_erro_frame,
    output logic [2:0] o_estado
);

    localparam int TW = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 2;

    // Line synchronizer: both flops reset to the idle (high) level so a reset
    // never looks like a falling start edge by itself.
    logic          r_sync1;
    logic          r_sync2;
    logic          w_rx;

    estado_t       r_estado;
    estado_t       w_estado_prox;
    logic [TW-1:0] r_timer;
    logic [2:0]    r_bit_cnt;
    logic [6:0]    r_shift;
    logic [6:0]    r_dados;
    logic          r_erro_frame;
    logic          r_erro_paridade;

    logic          w_fim_meio;
    logic          w_fim_bit;
    logic          w_timer_clr;
    logic          w_shift_en;
    logic          w_carrega;
    logic          w_erro_frame;
    logic          w_erro_paridade;
    logic          w_paridade_ok;

    assign w_rx       = r_sync2;
    assign w_fim_meio = (r_timer == TW'(HALF_DIV - 1));
    assign w_fim_bit  = (r_timer == TW'(BAUD_DIV - 1));

`ifdef RX_PARITY_CHECK_EN
    logic r_paridade;

    // Even parity: data bits plus parity bit must hold an even number of ones.
    assign w_paridade_ok = ~(^{r_shift, r_paridade});

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_paridade <= 1'b0;
        end else if (r_estado == ST_PARITY && w_fim_bit) begin
            r_paridade <= w_rx;
        end
    end
`else
    assign w_paridade_ok = 1'b1;
`endif

    // Next-state and per-cycle strobes.
    always_comb begin
        w_estado_prox   = r_estado;
        w_timer_clr     = 1'b0;
        w_shift_en      = 1'b0;
        w_carrega       = 1'b0;
        w_erro_frame    = 1'b0;
        w_erro_paridade = 1'b0;
        case (r_estado)
            ST_IDLE: begin
                w_timer_clr = 1'b1;
                if (!w_rx) begin
                    w_estado_prox = ST_START;
                end
            end
            ST_START: begin
                // Mid-start-bit check rejects short low glitches.
                if (w_fim_meio) begin
                    w_timer_clr   = 1'b1;
                    w_estado_prox = w_rx ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_fim_bit) begin
                    w_timer_clr = 1'b1;
                    w_shift_en  = 1'b1;
                    if (r_bit_cnt == 3'd6) begin
                        w_estado_prox = ST_PARITY;
                    end
                end
            end
            ST_PARITY: begin
                if (w_fim_bit) begin
                    w_timer_clr   = 1'b1;
                    w_estado_prox = ST_STOP;
                end
            end
            ST_STOP: begin
                if (w_fim_bit) begin
                    w_timer_clr = 1'b1;
                    // A low stop bit wins over a parity error so that the
                    // three status pulses stay mutually exclusive.
                    if (!w_rx) begin
                        w_erro_frame  = 1'b1;
                        w_estado_prox = ST_WAIT_IDLE;
                    end else if (w_paridade_ok) begin
                        w_carrega     = 1'b1;
                        w_estado_prox = ST_ENTREGA;
                    end else begin
                        w_erro_paridade = 1'b1;
                        w_estado_prox   = ST_IDLE;
                    end
                end
            end
            ST_ENTREGA: begin
                w_timer_clr   = 1'b1;
                w_estado_prox = ST_IDLE;
            end
            ST_WAIT_IDLE: begin
                // Break or stuck-low line: wait for the line to recover.
                w_timer_clr = 1'b1;
                if (w_rx) begin
                    w_estado_prox = ST_IDLE;
                end
            end
            default: begin
                w_timer_clr   = 1'b1;
                w_estado_prox = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_sync1         <= 1'b1;
            r_sync2         <= 1'b1;
            r_estado        <= ST_IDLE;
            r_timer         <= '0;
            r_bit_cnt       <= '0;
            r_shift         <= '0;
            r_dados         <= '0;
            r_erro_frame    <= 1'b0;
            r_erro_paridade <= 1'b0;
        end else begin
            r_sync1         <= i_rx;
            r_sync2         <= r_sync1;
            r_estado        <= w_estado_prox;
            r_erro_frame    <= w_erro_frame;
            r_erro_paridade <= w_erro_paridade;

            if (w_timer_clr) begin
                r_timer <= '0;
            end else begin
                r_timer <= r_timer + TW'(1);
            end

            // Bit counter only runs inside DATA; it restarts every character.
            if (r_estado != ST_DATA) begin
                r_bit_cnt <= '0;
            end else if (w_shift_en) begin
                r_bit_cnt <= r_bit_cnt + 3'd1;
            end

            // LSB arrives first, so shift in from the top.
            if (w_shift_en) begin
                r_shift <= {w_rx, r_shift[6:1]};
            end

            // Load on entry to ENTREGA so the character is already stable
            // during the pronto cycle.
            if (w_carrega) begin
                r_dados <= r_shift;
            end
        end
    end

    assign o_dados         = r_dados;
    assign o_pronto        = (r_estado == ST_ENTREGA);
    assign o_erro_frame    = r_erro_frame;
    assign o_erro_paridade = r_erro_paridade;
    assign o_estado        = r_estado;

endmodule

// File: rtl/receptor_medida_serial.sv
// Purpose: receives "XYZ#" ASCII frames over 7E1 serial and outputs a 12-bit BCD value.
// Latency: valor/valor_valido update 1 cycle after the pronto_rx of the '#'.
// Backpressure: none; the line cannot be stalled, status outputs are 1-cycle pulses.
//
// Ports:
//   clock, reset          system clock, synchronous active-high reset
//   entrada_serial        raw RX line (idles high)
//   dados_ascii/pronto_rx last character and its accept pulse
//   erro_paridade         parity error pulse (RX_PARITY_CHECK_EN only)
//   erro_frame            stop-bit error pulse
//   valor/valor_valido    last good BCD value {hundreds, tens, units} and update pulse
//   erro_formato          pulse when a partial/illegal frame is discarded
//   db_estado             receiver FSM state
// Optional: RX_PARITY_CHECK_EN (see receptor_medida_serial_rx_7E1).
module receptor_medida_serial
    import receptor_medida_serial_pkg::*;
#(
    parameter int BAUD_DIV = 434,
    parameter int HALF_DIV = BAUD_DIV / 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        entrada_serial,
    output logic [6:0]  dados_ascii,
    output logic        pronto_rx,
    output logic        erro_paridade,
    output logic        erro_frame,
    output logic [11:0] valor,
    output logic        valor_valido,
    output logic        erro_formato,
    output logic [2:0]  db_estado
);

    logic [6:0]  w_dados;
    logic        w_pronto;
    logic        w_erro_paridade;
    logic        w_erro_frame;
    logic [2:0]  w_estado;

    logic [1:0]  r_cont;
    logic [3:0]  r_slot0;
    logic [3:0]  r_slot1;
    logic [3:0]  r_slot2;
    logic [11:0] r_valor;
    logic        r_valor_valido;
    logic        r_erro_formato;

    logic        w_eh_digito;
    logic        w_eh_hash;
    logic        w_aceita_digito;
    logic        w_fecha;
    logic        w_descarta;

    receptor_medida_serial_rx_7E1 #(
        .BAUD_DIV (BAUD_DIV),
        .HALF_DIV (HALF_DIV)
    ) u_rx (
        .i_clock         (clock),
        .i_reset         (reset),
        .i_rx            (entrada_serial),
        .o_dados         (w_dados),
        .o_pronto        (w_pronto),
        .o_erro_paridade (w_erro_paridade),
        .o_erro_frame    (w_erro_frame),
        .o_estado        (w_estado)
    );

    assign w_eh_digito = eh_digito(w_dados);
    assign w_eh_hash   = (w_dados == ASCII_HASH);

    // Parser decisions. Anything that is neither an accepted digit nor a
    // closing '#' while a character is presented throws the frame away; a
    // line error only counts as a discard if a frame was in progress.
    always_comb begin
        w_aceita_digito = 1'b0;
        w_fecha         = 1'b0;
        w_descarta      = 1'b0;
        if (w_pronto) begin
            if (w_eh_digito && (r_cont != 2'd3)) begin
                w_aceita_digito = 1'b1;
            end else if (w_eh_hash && (r_cont == 2'd3)) begin
                w_fecha = 1'b1;
            end else begin
                w_descarta = 1'b1;
            end
        end else if ((w_erro_frame || w_erro_paridade) && (r_cont != 2'd0)) begin
            w_descarta = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_cont         <= '0;
            r_slot0        <= '0;
            r_slot1        <= '0;
            r_slot2        <= '0;
            r_valor        <= '0;
            r_valor_valido <= 1'b0;
            r_erro_formato <= 1'b0;
        end else begin
            r_valor_valido <= w_fecha;
            r_erro_formato <= w_descarta;

            if (w_aceita_digito) begin
                case (r_cont)
                    2'd0:    r_slot0 <= w_dados[3:0];
                    2'd1:    r_slot1 <= w_dados[3:0];
                    default: r_slot2 <= w_dados[3:0];
                endcase
                r_cont <= r_cont + 2'd1;
            end

            if (w_fecha) begin
                r_valor <= {r_slot0, r_slot1, r_slot2};
            end

            // After a close or a discard the next character starts a new frame.
            if (w_fecha || w_descarta) begin
                r_cont <= '0;
            end
        end
    end

    assign dados_ascii   = w_dados;
    assign pronto_rx     = w_pronto;
    assign erro_paridade = w_erro_paridade;
    assign erro_frame    = w_erro_frame;
    assign valor         = r_valor;
    assign valor_valido  = r_valor_valido;
    assign erro_formato  = r_erro_formato;
    assign db_estado     = w_estado;

endmodule

// File: tb/tb_receptor_medida_serial.sv
module tb_receptor_medida_serial;

    localparam int BAUD = 16;
    // 2 sync flops + 1 idle detect + HALF_DIV + 9 bit times (data, parity, stop)
    localparam int LAT_PRONTO = 2 + 1 + BAUD / 2 + 9 * BAUD;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        entrada_serial = 1'b1;
    logic [6:0]  dados_ascii;
    logic        pronto_rx;
    logic        erro_paridade;
    logic        erro_frame;
    logic [11:0] valor;
    logic        valor_valido;
    logic        erro_formato;
    logic [2:0]  db_estado;

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    int tx_start_cyc = 0;

    // Event logs filled by the monitor
    logic [6:0] pr_dados[$];
    int         pr_cyc[$];
    int         vv_cyc[$];
    int         n_fmt = 0;
    int         n_frm = 0;
    int         n_par = 0;
    int         n_excl = 0;

    receptor_medida_serial #(.BAUD_DIV(BAUD)) dut (
        .clock          (clock),
        .reset          (reset),
        .entrada_serial (entrada_serial),
        .dados_ascii    (dados_ascii),
        .pronto_rx      (pronto_rx),
        .erro_paridade  (erro_paridade),
        .erro_frame     (erro_frame),
        .valor          (valor),
        .valor_valido   (valor_valido),
        .erro_formato   (erro_formato),
        .db_estado      (db_estado)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (pronto_rx) begin
            pr_dados.push_back(dados_ascii);
            pr_cyc.push_back(cyc);
        end
        if (valor_valido) vv_cyc.push_back(cyc);
        if (erro_formato) n_fmt++;
        if (erro_frame) n_frm++;
        if (erro_paridade) n_par++;
        if (({1'b0, pronto_rx} + {1'b0, erro_frame} + {1'b0, erro_paridade}) > 2'd1) n_excl++;
    end

    task automatic send_char(input logic [6:0] c, input logic par_flip, input logic stop_bit);
        logic [9:0] f;
        f = {stop_bit, (^c) ^ par_flip, c, 1'b0};
        @(negedge clock);
        tx_start_cyc = cyc;
        for (int i = 0; i < 10; i++) begin
            entrada_serial = f[i];
            repeat (BAUD) @(negedge clock);
        end
    endtask

    task automatic idle(input int n);
        entrada_serial = 1'b1;
        repeat (n) @(negedge clock);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(negedge clock);
        n_cmp++; if (dados_ascii !== 7'h00) begin n_fail++; $display("FAIL reset_dados got %h want 00", dados_ascii); end
        n_cmp++; if (pronto_rx !== 1'b0) begin n_fail++; $display("FAIL reset_pronto got %b want 0", pronto_rx); end
        n_cmp++; if (erro_paridade !== 1'b0) begin n_fail++; $display("FAIL reset_erro_paridade got %b want 0", erro_paridade); end
        n_cmp++; if (erro_frame !== 1'b0) begin n_fail++; $display("FAIL reset_erro_frame got %b want 0", erro_frame); end
        n_cmp++; if (valor !== 12'h000) begin n_fail++; $display("FAIL reset_valor got %h want 000", valor); end
        n_cmp++; if (valor_valido !== 1'b0) begin n_fail++; $display("FAIL reset_valor_valido got %b want 0", valor_valido); end
        n_cmp++; if (erro_formato !== 1'b0) begin n_fail++; $display("FAIL reset_erro_formato got %b want 0", erro_formato); end
        n_cmp++; if (db_estado !== 3'd0) begin n_fail++; $display("FAIL reset_estado got %0d want 0", db_estado); end
        reset = 1'b0;
        idle(10);
    endtask

    task automatic test_valid_frame;
        int bp, bv, bf;
        bp = pr_dados.size(); bv = vv_cyc.size(); bf = n_fmt;
        send_char(7'h31, 1'b0, 1'b1);
        send_char(7'h32, 1'b0, 1'b1);
        send_char(7'h33, 1'b0, 1'b1);
        send_char(7'h23, 1'b0, 1'b1);
        idle(20);
        n_cmp++; if (pr_dados.size() - bp !== 4) begin n_fail++; $display("FAIL valid_pronto_count got %0d want 4", pr_dados.size() - bp); end
        if (pr_dados.size() - bp == 4) begin
            n_cmp++; if (pr_dados[bp] !== 7'h31) begin n_fail++; $display("FAIL valid_char0 got %h want 31", pr_dados[bp]); end
            n_cmp++; if (pr_dados[bp+1] !== 7'h32) begin n_fail++; $display("FAIL valid_char1 got %h want 32", pr_dados[bp+1]); end
            n_cmp++; if (pr_dados[bp+2] !== 7'h33) begin n_fail++; $display("FAIL valid_char2 got %h want 33", pr_dados[bp+2]); end
            n_cmp++; if (pr_dados[bp+3] !== 7'h23) begin n_fail++; $display("FAIL valid_char3 got %h want 23", pr_dados[bp+3]); end
            n_cmp++; if (pr_cyc[bp+3] - tx_start_cyc !== LAT_PRONTO) begin n_fail++; $display("FAIL pronto_latency got %0d want %0d", pr_cyc[bp+3] - tx_start_cyc, LAT_PRONTO); end
        end
        n_cmp++; if (valor !== 12'h123) begin n_fail++; $display("FAIL valid_valor got %h want 123", valor); end
        n_cmp++; if (vv_cyc.size() - bv !== 1) begin n_fail++; $display("FAIL valid_vv_count got %0d want 1", vv_cyc.size() - bv); end
        if (vv_cyc.size() - bv == 1 && pr_cyc.size() > 0) begin
            n_cmp++; if (vv_cyc[bv] !== pr_cyc[pr_cyc.size()-1] + 1) begin n_fail++; $display("FAIL valid_vv_timing got %0d want %0d", vv_cyc[bv], pr_cyc[pr_cyc.size()-1] + 1); end
        end
        n_cmp++; if (n_fmt - bf !== 0) begin n_fail++; $display("FAIL valid_fmt got %0d want 0", n_fmt - bf); end
    endtask

    task automatic test_short_frame;
        int bv, bf;
        bv = vv_cyc.size(); bf = n_fmt;
        send_char(7'h34, 1'b0, 1'b1);
        send_char(7'h35, 1'b0, 1'b1);
        send_char(7'h23, 1'b0, 1'b1);
        idle(20);
        n_cmp++; if (n_fmt - bf !== 1) begin n_fail++; $display("FAIL short_fmt got %0d want 1", n_fmt - bf); end
        n_cmp++; if (valor !== 12'h123) begin n_fail++; $display("FAIL short_valor got %h want 123", valor); end
        n_cmp++; if (vv_cyc.size() - bv !== 0) begin n_fail++; $display("FAIL short_vv got %0d want 0", vv_cyc.size() - bv); end
        bv = vv_cyc.size();
        send_char(7'h39, 1'b0, 1'b1);
        send_char(7'h38, 1'b0, 1'b1);
        send_char(7'h37, 1'b0, 1'b1);
        send_char(7'h23, 1'b0, 1'b1);
        idle(20);
        n_cmp++; if (valor !== 12'h987) begin n_fail++; $display("FAIL b2b_valor got %h want 987", valor); end
        n_cmp++; if (vv_cyc.size() - bv !== 1) begin n_fail++; $display("FAIL b2b_vv got %0d want 1", vv_cyc.size() - bv); end
    endtask

    task automatic test_parity;
        int bp, bpar, bf;
        bp = pr_dados.size(); bpar = n_par; bf = n_fmt;
        send_char(7'h35, 1'b1, 1'b1);
        idle(20);
`ifdef RX_PARITY_CHECK_EN
        n_cmp++; if (n_par - bpar !== 1) begin n_fail++; $display("FAIL parity_err got %0d want 1", n_par - bpar); end
        n_cmp++; if (pr_dados.size() - bp !== 0) begin n_fail++; $display("FAIL parity_pronto got %0d want 0", pr_dados.size() - bp); end
`else
        n_cmp++; if (n_par - bpar !== 0) begin n_fail++; $display("FAIL parity_err got %0d want 0", n_par - bpar); end
        n_cmp++; if (pr_dados.size() - bp !== 1) begin n_fail++; $display("FAIL parity_pronto got %0d want 1", pr_dados.size() - bp); end
        if (pr_dados.size() - bp == 1) begin
            n_cmp++; if (pr_dados[bp] !== 7'h35) begin n_fail++; $display("FAIL parity_dados got %h want 35", pr_dados[bp]); end
        end
`endif
        // Error at count 0 must not discard; the following '#' always does.
        n_cmp++; if (n_fmt - bf !== 0) begin n_fail++; $display("FAIL parity_fmt_early got %0d want 0", n_fmt - bf); end
        send_char(7'h23, 1'b0, 1'b1);
        idle(20);
        n_cmp++; if (n_fmt - bf !== 1) begin n_fail++; $display("FAIL parity_fmt_hash got %0d want 1", n_fmt - bf); end
    endtask

    task automatic test_frame_error;
        int bfr, bf, bp, bv;
        bfr = n_frm; bf = n_fmt; bp = pr_dados.size();
        send_char(7'h37, 1'b0, 1'b0);
        repeat (40) @(negedge clock);
        n_cmp++; if (db_estado !== 3'd6) begin n_fail++; $display("FAIL frame_wait_idle got %0d want 6", db_estado); end
        n_cmp++; if (n_frm - bfr !== 1) begin n_fail++; $display("FAIL frame_err_count got %0d want 1", n_frm - bfr); end
        n_cmp++; if (n_fmt - bf !== 0) begin n_fail++; $display("FAIL frame_fmt_count0 got %0d want 0", n_fmt - bf); end
        n_cmp++; if (pr_dados.size() - bp !== 0) begin n_fail++; $display("FAIL frame_pronto got %0d want 0", pr_dados.size() - bp); end
        idle(20);
        n_cmp++; if (db_estado !== 3'd0) begin n_fail++; $display("FAIL frame_back_idle got %0d want 0", db_estado); end
        // Frame error with a frame in progress discards it.
        bfr = n_frm; bf = n_fmt;
        send_char(7'h31, 1'b0, 1'b1);
        send_char(7'h38, 1'b0, 1'b0);
        idle(20);
        n_cmp++; if (n_frm - bfr !== 1) begin n_fail++; $display("FAIL frame_err2 got %0d want 1", n_frm - bfr); end
        n_cmp++; if (n_fmt - bf !== 1) begin n_fail++; $display("FAIL frame_fmt_midframe got %0d want 1", n_fmt - bf); end
        bv = vv_cyc.size();
        send_char(7'h30, 1'b0, 1'b1);
        send_char(7'h30, 1'b0, 1'b1);
        send_char(7'h31, 1'b0, 1'b1);
        send_char(7'h23, 1'b0, 1'b1);
        idle(20);
        n_cmp++; if (valor !== 12'h001) begin n_fail++; $display("FAIL frame_recover_valor got %h want 001", valor); end
        n_cmp++; if (vv_cyc.size() - bv !== 1) begin n_fail++; $display("FAIL frame_recover_vv got %0d want 1", vv_cyc.size() - bv); end
    endtask

    task automatic test_glitch;
        int bp, bfr, bf;
        bp = pr_dados.size(); bfr = n_frm; bf = n_fmt;
        @(negedge clock);
        entrada_serial = 1'b0;
        repeat (3) @(negedge clock);
        n_cmp++; if (db_estado !== 3'd1) begin n_fail++; $display("FAIL glitch_start got %0d want 1", db_estado); end
        repeat (2) @(negedge clock);
        idle(40);
        n_cmp++; if (db_estado !== 3'd0) begin n_fail++; $display("FAIL glitch_idle got %0d want 0", db_estado); end
        n_cmp++; if (pr_dados.size() - bp !== 0) begin n_fail++; $display("FAIL glitch_pronto got %0d want 0", pr_dados.size() - bp); end
        n_cmp++; if (n_frm - bfr !== 0) begin n_fail++; $display("FAIL glitch_frame got %0d want 0", n_frm - bfr); end
        n_cmp++; if (n_fmt - bf !== 0) begin n_fail++; $display("FAIL glitch_fmt got %0d want 0", n_fmt - bf); end
    endtask

    task automatic test_reset_mid;
        logic [6:0] c;
        logic [9:0] f;
        int bv, bf;
        send_char(7'h31, 1'b0, 1'b1);
        c = 7'h32;
        f = {1'b1, ^c, c, 1'b0};
        @(negedge clock);
        for (int i = 0; i < 10; i++) begin
            entrada_serial = f[i];
            if (i == 4) begin
                repeat (BAUD / 2) @(negedge clock);
                n_cmp++; if (db_estado !== 3'd2) begin n_fail++; $display("FAIL rstmid_pre_state got %0d want 2", db_estado); end
                reset = 1'b1;
                @(negedge clock);
                n_cmp++; if (valor !== 12'h000) begin n_fail++; $display("FAIL rstmid_valor got %h want 000", valor); end
                n_cmp++; if (dados_ascii !== 7'h00) begin n_fail++; $display("FAIL rstmid_dados got %h want 00", dados_ascii); end
                n_cmp++; if (db_estado !== 3'd0) begin n_fail++; $display("FAIL rstmid_state got %0d want 0", db_estado); end
                n_cmp++; if ({pronto_rx, erro_frame, erro_paridade, valor_valido, erro_formato} !== 5'b0) begin
                    n_fail++; $display("FAIL rstmid_pulses got %b want 00000", {pronto_rx, erro_frame, erro_paridade, valor_valido, erro_formato});
                end
                reset = 1'b0;
                repeat (BAUD / 2 - 1) @(negedge clock);
            end else begin
                repeat (BAUD) @(negedge clock);
            end
        end
        idle(300);
        bv = vv_cyc.size(); bf = n_fmt;
        send_char(7'h34, 1'b0, 1'b1);
        send_char(7'h35, 1'b0, 1'b1);
        send_char(7'h36, 1'b0, 1'b1);
        send_char(7'h23, 1'b0, 1'b1);
        idle(20);
        n_cmp++; if (valor !== 12'h456) begin n_fail++; $display("FAIL rstmid_valor_after got %h want 456", valor); end
        n_cmp++; if (vv_cyc.size() - bv !== 1) begin n_fail++; $display("FAIL rstmid_vv got %0d want 1", vv_cyc.size() - bv); end
        n_cmp++; if (n_fmt - bf !== 0) begin n_fail++; $display("FAIL rstmid_fmt got %0d want 0", n_fmt - bf); end
    endtask

    initial begin
        test_reset;
        test_valid_frame;
        test_short_frame;
        test_parity;
        test_frame_error;
        test_glitch;
        test_reset_mid;
        n_cmp++; if (n_excl !== 0) begin n_fail++; $display("FAIL status_exclusive got %0d want 0", n_excl); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
